// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one combinational ALU, with a one-entry registered response buffer.
// Define ALU_ARB_FIXED_PRIO_EN to give r0 fixed priority; default build is round-robin.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic [OP_WIDTH-1:0]   r0_op,
    input  logic [DATA_WIDTH-1:0] r0_in_1,
    input  logic [DATA_WIDTH-1:0] r0_in_2,
    output logic                  r0_rsp_valid,
    input  logic                  r0_rsp_ready,
    output logic [DATA_WIDTH-1:0] r0_rsp_result,
    output logic                  r0_rsp_bcond,
    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic [OP_WIDTH-1:0]   r1_op,
    input  logic [DATA_WIDTH-1:0] r1_in_1,
    input  logic [DATA_WIDTH-1:0] r1_in_2,
    output logic                  r1_rsp_valid,
    input  logic                  r1_rsp_ready,
    output logic [DATA_WIDTH-1:0] r1_rsp_result,
    output logic                  r1_rsp_bcond,
    output logic [OP_WIDTH-1:0]   alu_op,
    output logic [DATA_WIDTH-1:0] alu_in_1,
    output logic [DATA_WIDTH-1:0] alu_in_2,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_bcond
);

    logic                  rsp_full_q,   rsp_full_d;
    logic                  rsp_owner_q,  rsp_owner_d;
    logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic                  rsp_bcond_q,  rsp_bcond_d;
    logic                  last_grant_q, last_grant_d;

    logic [1:0] req_valid;
    logic [1:0] req_rsp_ready;
    logic [1:0] req_ready;
    logic [1:0] req_rsp_valid;

    logic drain;
    logic can_accept;
    logic grant;
    logic accept;

    assign req_valid     = {r1_valid, r0_valid};
    assign req_rsp_ready = {r1_rsp_ready, r0_rsp_ready};

    assign drain      = rsp_full_q && req_rsp_ready[rsp_owner_q];
    // Gated by reset_n so ready reads 0 while reset is held, not only after the registers clear.
    assign can_accept = reset_n && (!rsp_full_q || drain);

    always_comb begin
        grant = ~last_grant_q;
        if (req_valid == 2'b01) begin
            grant = 1'b0;
        end else if (req_valid == 2'b10) begin
            grant = 1'b1;
        end else if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant = 1'b0;
`else
            grant = ~last_grant_q;
`endif
        end
    end

    assign accept = can_accept && req_valid[grant];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign req_ready[gi]     = accept && (grant == gi[0]);
            assign req_rsp_valid[gi] = rsp_full_q && (rsp_owner_q == gi[0]);
        end
    endgenerate

    assign r0_ready      = req_ready[0];
    assign r1_ready      = req_ready[1];
    assign r0_rsp_valid  = req_rsp_valid[0];
    assign r1_rsp_valid  = req_rsp_valid[1];
    assign r0_rsp_result = rsp_result_q;
    assign r1_rsp_result = rsp_result_q;
    assign r0_rsp_bcond  = rsp_bcond_q;
    assign r1_rsp_bcond  = rsp_bcond_q;

    always_comb begin
        alu_op   = '0;
        alu_in_1 = '0;
        alu_in_2 = '0;
        if (accept) begin
            alu_op   = grant ? r1_op   : r0_op;
            alu_in_1 = grant ? r1_in_1 : r0_in_1;
            alu_in_2 = grant ? r1_in_2 : r0_in_2;
        end
    end

    always_comb begin
        rsp_full_d   = rsp_full_q;
        rsp_owner_d  = rsp_owner_q;
        rsp_result_d = rsp_result_q;
        rsp_bcond_d  = rsp_bcond_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            rsp_full_d   = 1'b1;
            rsp_owner_d  = grant;
            rsp_result_d = alu_result;
            rsp_bcond_d  = alu_bcond;
            last_grant_d = grant;
        end else if (drain) begin
            rsp_full_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_full_q   <= 1'b0;
            rsp_owner_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_bcond_q  <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            rsp_full_q   <= rsp_full_d;
            rsp_owner_q  <= rsp_owner_d;
            rsp_result_q <= rsp_result_d;
            rsp_bcond_q  <= rsp_bcond_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the alu_* side.
// Honours ALU_ARB_FIXED_PRIO_EN in the both-valid arbitration expectations.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int OW = 7;

    localparam logic [3:0] FUNC_ADD  = 4'b0000;
    localparam logic [3:0] FUNC_SUB  = 4'b1000;
    localparam logic [1:0] BRANCH_EQ = 2'b00;
    localparam logic [1:0] BRANCH_NE = 2'b01;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          r0_valid = 1'b0, r1_valid = 1'b0;
    logic          r0_ready, r1_ready;
    logic [OW-1:0] r0_op = '0, r1_op = '0;
    logic [DW-1:0] r0_in_1 = '0, r0_in_2 = '0, r1_in_1 = '0, r1_in_2 = '0;
    logic          r0_rsp_valid, r1_rsp_valid;
    logic          r0_rsp_ready = 1'b0, r1_rsp_ready = 1'b0;
    logic [DW-1:0] r0_rsp_result, r1_rsp_result;
    logic          r0_rsp_bcond, r1_rsp_bcond;
    logic [OW-1:0] alu_op;
    logic [DW-1:0] alu_in_1, alu_in_2;
    logic [DW-1:0] alu_result;
    logic          alu_bcond;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
        .clk(clk), .reset_n(reset_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op),
        .r0_in_1(r0_in_1), .r0_in_2(r0_in_2),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
        .r0_rsp_result(r0_rsp_result), .r0_rsp_bcond(r0_rsp_bcond),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op),
        .r1_in_1(r1_in_1), .r1_in_2(r1_in_2),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
        .r1_rsp_result(r1_rsp_result), .r1_rsp_bcond(r1_rsp_bcond),
        .alu_op(alu_op), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
        .alu_result(alu_result), .alu_bcond(alu_bcond)
    );

    // Stand-in ALU: add/sub on func, equality-style branch conditions on op[5:4].
    always_comb begin
        alu_result = (alu_op[3:0] == FUNC_SUB) ? alu_in_1 - alu_in_2 : alu_in_1 + alu_in_2;
        alu_bcond  = 1'b0;
        if (alu_op[6]) begin
            case (alu_op[5:4])
                BRANCH_EQ: alu_bcond = (alu_in_1 == alu_in_2);
                BRANCH_NE: alu_bcond = (alu_in_1 != alu_in_2);
                2'b10:     alu_bcond = ($signed(alu_in_1) < $signed(alu_in_2));
                default:   alu_bcond = ($signed(alu_in_1) >= $signed(alu_in_2));
            endcase
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OW-1:0] mk_op(input logic br, input logic [1:0] bt, input logic [3:0] fn);
        return {br, bt, fn};
    endfunction

    initial begin
        int exp_w;
        int prev_w;

        // Reset state while a request is already presented.
        r0_valid = 1'b1; r0_op = mk_op(1'b0, 2'b00, FUNC_ADD); r0_in_1 = 5; r0_in_2 = 7;
        r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
        #2;
        check("rst r0_ready", r0_ready, 0);
        check("rst r1_ready", r1_ready, 0);
        check("rst r0_rsp_valid", r0_rsp_valid, 0);
        check("rst r1_rsp_valid", r1_rsp_valid, 0);
        check("rst rsp_result", r0_rsp_result, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // Single r0 ADD 5+7.
        check("add r0_ready", r0_ready, 1);
        check("add alu_in_1", alu_in_1, 5);
        check("add alu_in_2", alu_in_2, 7);
        next_cycle();
        r0_valid = 1'b0;
        @(negedge clk);
        check("add r0_rsp_valid", r0_rsp_valid, 1);
        check("add r0_rsp_result", r0_rsp_result, 12);
        check("add r1_rsp_valid", r1_rsp_valid, 0);
        check("idle alu_in_1", alu_in_1, 0);
        check("idle alu_op", alu_op, 0);
        next_cycle();

        // r1 branch EQ via SUB: 9-9 then 9-8 back to back.
        r1_valid = 1'b1; r1_op = mk_op(1'b1, BRANCH_EQ, FUNC_SUB); r1_in_1 = 9; r1_in_2 = 9;
        @(negedge clk);
        check("br1 r1_ready", r1_ready, 1);
        check("br1 alu_op", alu_op, 7'b1001000);
        next_cycle();
        r1_in_2 = 8;
        @(negedge clk);
        check("br1 r1_rsp_valid", r1_rsp_valid, 1);
        check("br1 r1_rsp_bcond", r1_rsp_bcond, 1);
        check("br1 r1_rsp_result", r1_rsp_result, 0);
        check("br2 r1_ready", r1_ready, 1);
        next_cycle();
        r1_valid = 1'b0;
        @(negedge clk);
        check("br2 r1_rsp_valid", r1_rsp_valid, 1);
        check("br2 r1_rsp_bcond", r1_rsp_bcond, 0);
        check("br2 r1_rsp_result", r1_rsp_result, 1);
        next_cycle();

        // Both valid every cycle; last grant was r1, so r0 goes first.
        r0_op = mk_op(1'b0, 2'b00, FUNC_ADD); r0_in_1 = 1; r0_in_2 = 1;
        r1_op = mk_op(1'b0, 2'b00, FUNC_ADD); r1_in_1 = 2; r1_in_2 = 2;
        prev_w = -1;
        for (int i = 0; i < 5; i++) begin
            r0_valid = (i < 4);
            r1_valid = (i < 4);
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_w = 0;
`else
            exp_w = i % 2;
`endif
            @(negedge clk);
            if (i < 4) begin
                check($sformatf("rr%0d r0_ready", i), r0_ready, (exp_w == 0) ? 1 : 0);
                check($sformatf("rr%0d r1_ready", i), r1_ready, (exp_w == 1) ? 1 : 0);
            end
            if (prev_w >= 0) begin
                check($sformatf("rr%0d r0_rsp_valid", i), r0_rsp_valid, (prev_w == 0) ? 1 : 0);
                check($sformatf("rr%0d r1_rsp_valid", i), r1_rsp_valid, (prev_w == 1) ? 1 : 0);
                check($sformatf("rr%0d rsp_result", i), r0_rsp_result, (prev_w == 0) ? 2 : 4);
            end
            prev_w = exp_w;
            next_cycle();
        end

        // Stalled owner blocks the other requester.
        r0_valid = 1'b1; r0_in_1 = 3; r0_in_2 = 4; r0_rsp_ready = 1'b0;
        @(negedge clk);
        check("stall r0_ready", r0_ready, 1);
        next_cycle();
        r0_valid = 1'b0;
        r1_valid = 1'b1; r1_in_1 = 10; r1_in_2 = 20;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d r1_ready", i), r1_ready, 0);
            check($sformatf("stall%0d r0_rsp_result", i), r0_rsp_result, 7);
            next_cycle();
        end
        r0_rsp_ready = 1'b1;
        @(negedge clk);
        check("unstall r1_ready", r1_ready, 1);
        next_cycle();
        r1_valid = 1'b0;
        @(negedge clk);
        check("unstall r1_rsp_valid", r1_rsp_valid, 1);
        check("unstall r0_rsp_valid", r0_rsp_valid, 0);
        check("unstall r1_rsp_result", r1_rsp_result, 30);
        next_cycle();

        // Asynchronous reset with a full buffer, then arbitration restarts at r0.
        r0_valid = 1'b1; r0_in_1 = 1; r0_in_2 = 2; r0_rsp_ready = 1'b0;
        next_cycle();
        r1_valid = 1'b1;
        @(negedge clk);
        check("arst pre r0_rsp_valid", r0_rsp_valid, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst r0_rsp_valid", r0_rsp_valid, 0);
        check("arst r1_rsp_valid", r1_rsp_valid, 0);
        check("arst r0_ready", r0_ready, 0);
        check("arst r1_ready", r1_ready, 0);
        reset_n = 1'b1;
        #1;
        check("post r0_ready", r0_ready, 1);
        check("post r1_ready", r1_ready, 0);
        next_cycle();
        r0_valid = 1'b0; r1_valid = 1'b0;
        @(negedge clk);
        check("post r0_rsp_valid", r0_rsp_valid, 1);
        check("post r0_rsp_result", r0_rsp_result, 3);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
